// File: rtl/reg_dump_reader_pkg.sv
// Shared parameters and state encoding for the register dump reader.
// Optional build macro: DUMP_CHECKSUM_EN adds the CKSUM state.
package reg_dump_reader_pkg;

    localparam int DEF_NB_DATA = 32;  // register word width
    localparam int DEF_NB_REG  = 5;   // register address width
    localparam int DEF_NB_BYTE = 8;   // transmit byte width
    localparam int DEF_N_REGS  = 32;  // registers dumped per request

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SET_ADDR = 3'd1,
        CAPTURE  = 3'd2,
        SEND     = 3'd3,
        NEXT     = 3'd4,
`ifdef DUMP_CHECKSUM_EN
        CKSUM    = 3'd5,
`endif
        DONE     = 3'd6
    } state_t;

endpackage

// File: rtl/reg_dump_reader_byte_serializer.sv
// dump_byte_serializer: holds one captured word and hands it to the UART
// transmitter MSB byte first over a valid/ready handshake. A "single" load
// sends only the low byte of i_word (used for the trailing checksum byte).
module dump_byte_serializer
    import reg_dump_reader_pkg::*;
#(
    parameter int NB_DATA = DEF_NB_DATA,
    parameter int NB_BYTE = DEF_NB_BYTE
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_load,
    input  logic               i_load_single,
    input  logic [NB_DATA-1:0] i_word,
    output logic [NB_BYTE-1:0] o_tx_data,
    output logic               o_tx_valid,
    input  logic               i_tx_ready,
    output logic               o_last
);

    localparam int N_BYTES = NB_DATA / NB_BYTE;
    localparam int NB_CNT  = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
    localparam logic [NB_CNT-1:0] LAST_CNT = NB_CNT'(N_BYTES - 1);

    logic [NB_DATA-1:0] word;
    logic [NB_CNT-1:0]  cnt;
    logic               valid;
    logic               xfer;

    assign xfer       = valid & i_tx_ready;
    assign o_tx_data  = word[NB_DATA-1 -: NB_BYTE];
    assign o_tx_valid = valid;
    assign o_last     = xfer && (cnt == LAST_CNT);

    // Word shifts left after each accepted byte so the offered byte is always
    // the top slice and cannot change while the transmitter stalls.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            word  <= '0;
            cnt   <= '0;
            valid <= 1'b0;
        end else if (i_load) begin
            word  <= i_load_single ? {i_word[NB_BYTE-1:0], {(NB_DATA-NB_BYTE){1'b0}}}
                                   : i_word;
            cnt   <= i_load_single ? LAST_CNT : '0;
            valid <= 1'b1;
        end else if (xfer) begin
            if (cnt == LAST_CNT) begin
                valid <= 1'b0;
            end else begin
                word <= word << NB_BYTE;
                cnt  <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/reg_dump_reader.sv
// reg_dump_reader: while the pipeline is halted, walks all registers through
// the debug read port and streams their contents out as bytes.
// Optional build macro: DUMP_CHECKSUM_EN appends an XOR checksum byte.
module reg_dump_reader
    import reg_dump_reader_pkg::*;
#(
    parameter int NB_DATA = DEF_NB_DATA,
    parameter int NB_REG  = DEF_NB_REG,
    parameter int NB_BYTE = DEF_NB_BYTE,
    parameter int N_REGS  = DEF_N_REGS
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_start,
    input  logic               i_halted,
    output logic               o_br_enable,
    output logic [NB_REG-1:0]  o_br_addr,
    input  logic [NB_DATA-1:0] i_br_data,
    output logic [NB_BYTE-1:0] o_tx_data,
    output logic               o_tx_valid,
    input  logic               i_tx_ready,
    output logic               o_busy,
    output logic               o_done
);

    state_t             state;
    state_t             next_state;
    logic [NB_REG-1:0]  index;
    logic               last_idx;
    logic               ser_load;
    logic               ser_single;
    logic               ser_last;
    logic [NB_DATA-1:0] ser_word;

    assign last_idx  = (index == NB_REG'(N_REGS - 1));
    assign o_br_addr = index;

    // State register
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) state <= IDLE;
        else          state <= next_state;
    end

    // Next-state logic; start requests are only looked at in IDLE
    always_comb begin
        next_state = state;
        case (state)
            IDLE:     if (i_start && i_halted) next_state = SET_ADDR;
            SET_ADDR: next_state = CAPTURE;
            CAPTURE:  next_state = SEND;
            SEND:     if (ser_last) next_state = NEXT;
            NEXT: begin
                if (last_idx) begin
`ifdef DUMP_CHECKSUM_EN
                    next_state = CKSUM;
`else
                    next_state = DONE;
`endif
                end else begin
                    next_state = SET_ADDR;
                end
            end
`ifdef DUMP_CHECKSUM_EN
            CKSUM:    if (ser_last) next_state = DONE;
`endif
            DONE:     next_state = IDLE;
            default:  next_state = IDLE;
        endcase
    end

    // Output decode: busy/read-port select across the whole dump, done pulse in DONE
    always_comb begin
        o_busy      = (state != IDLE) && (state != DONE);
        o_br_enable = (state != IDLE) && (state != DONE);
        o_done      = (state == DONE);
        ser_load    = (state == CAPTURE);
        ser_single  = 1'b0;
`ifdef DUMP_CHECKSUM_EN
        if ((state == NEXT) && last_idx) begin
            ser_load   = 1'b1;
            ser_single = 1'b1;
        end
`endif
    end

    // Register index: advances between words, returns to 0 as the dump completes
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset)                            index <= '0;
        else if (next_state == DONE)             index <= '0;
        else if ((state == NEXT) && !last_idx)   index <= index + 1'b1;
    end

`ifdef DUMP_CHECKSUM_EN
    logic [NB_BYTE-1:0] cksum;

    // Running XOR of every register byte accepted by the transmitter
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset)                                      cksum <= '0;
        else if (state == IDLE)                            cksum <= '0;
        else if ((state == SEND) && o_tx_valid && i_tx_ready) cksum <= cksum ^ o_tx_data;
    end

    assign ser_word = (state == NEXT) ? NB_DATA'(cksum) : i_br_data;
`else
    assign ser_word = i_br_data;
`endif

    dump_byte_serializer #(
        .NB_DATA (NB_DATA),
        .NB_BYTE (NB_BYTE)
    ) u_serializer (
        .i_clock       (i_clock),
        .i_reset       (i_reset),
        .i_load        (ser_load),
        .i_load_single (ser_single),
        .i_word        (ser_word),
        .o_tx_data     (o_tx_data),
        .o_tx_valid    (o_tx_valid),
        .i_tx_ready    (i_tx_ready),
        .o_last        (ser_last)
    );

endmodule

// File: tb/tb_reg_dump_reader.sv
// Directed bench for reg_dump_reader: register file model with one-cycle read
// latency, byte collector, and immediate-assertion checks.
module tb_reg_dump_reader;

    localparam int NB_DATA = 32;
    localparam int NB_REG  = 5;
    localparam int NB_BYTE = 8;
    localparam int N_REGS  = 32;
    localparam int N_DATA_BYTES = 4 * N_REGS;
`ifdef DUMP_CHECKSUM_EN
    localparam int N_STREAM = N_DATA_BYTES + 1;
`else
    localparam int N_STREAM = N_DATA_BYTES;
`endif
    localparam int BUDGET = 5000;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               start;
    logic               halted;
    logic               br_enable;
    logic [NB_REG-1:0]  br_addr;
    logic [NB_DATA-1:0] br_data;
    logic [NB_BYTE-1:0] tx_data;
    logic               tx_valid;
    logic               tx_ready;
    logic               busy;
    logic               done;

    logic [31:0] regs [N_REGS];
    logic [7:0]  got [$];
    int          dones;
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    // register file read port: data follows the address by one cycle
    always @(posedge clk) br_data <= regs[br_addr];

    reg_dump_reader #(
        .NB_DATA (NB_DATA),
        .NB_REG  (NB_REG),
        .NB_BYTE (NB_BYTE),
        .N_REGS  (N_REGS)
    ) dut (
        .i_clock     (clk),
        .i_reset     (rst_n),
        .i_start     (start),
        .i_halted    (halted),
        .o_br_enable (br_enable),
        .o_br_addr   (br_addr),
        .i_br_data   (br_data),
        .o_tx_data   (tx_data),
        .o_tx_valid  (tx_valid),
        .i_tx_ready  (tx_ready),
        .o_busy      (busy),
        .o_done      (done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_dump();
        halted = 1'b1;
        start  = 1'b1;
        tick();
        start  = 1'b0;
    endtask

    function automatic logic [7:0] exp_byte(input int k);
        logic [31:0] w;
        w = regs[k / 4];
        return 8'(w >> (8 * (3 - (k % 4))));
    endfunction

    // mode 0: ready always high; mode 1: ready 1,0,0,1 repeating;
    // mode 2: ready high plus start pulses at bytes 10 and 100.
    // stop_at > 0 leaves the loop while byte number stop_at is being offered.
    task automatic collect(input int mode, input int stop_at);
        int         cyc;
        logic       stalled;
        logic [7:0] held;
        logic       timed_out;
        cyc       = 0;
        stalled   = 1'b0;
        held      = 8'h00;
        timed_out = 1'b1;
        dones     = 0;
        got.delete();
        while (cyc < BUDGET) begin
            if (mode == 1) tx_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
            else           tx_ready = 1'b1;
            start = (mode == 2) && (got.size() == 10 || got.size() == 100);
            #1;
            if (stalled) chk("stall_hold", {23'h0, tx_valid, tx_data}, {23'h0, 1'b1, held});
            stalled = tx_valid && !tx_ready;
            held    = tx_data;
            if (tx_valid && tx_ready) got.push_back(tx_data);
            if (done) dones++;
            if (done || (stop_at > 0 && got.size() == stop_at)) begin
                timed_out = 1'b0;
                break;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        start    = 1'b0;
        tx_ready = 1'b1;
        chk("collect_timeout", 32'(timed_out), 32'h0);
    endtask

    task automatic check_stream(input string tag);
        int         nbad;
        logic [7:0] x;
        nbad = 0;
        x    = 8'h00;
        chk({tag, "_count"}, 32'(got.size()), 32'(N_STREAM));
        for (int k = 0; k < got.size() && k < N_DATA_BYTES; k++) begin
            if (got[k] !== exp_byte(k)) nbad++;
        end
        for (int k = 0; k < N_DATA_BYTES; k++) x ^= exp_byte(k);
        chk({tag, "_bad_bytes"}, 32'(nbad), 32'h0);
        if (got.size() > 0) chk({tag, "_first"}, {24'h0, got[0]}, {24'h0, exp_byte(0)});
        if (got.size() >= N_DATA_BYTES)
            chk({tag, "_last"}, {24'h0, got[N_DATA_BYTES-1]}, {24'h0, exp_byte(N_DATA_BYTES-1)});
`ifdef DUMP_CHECKSUM_EN
        if (got.size() == N_STREAM) chk({tag, "_cksum"}, {24'h0, got[N_STREAM-1]}, {24'h0, x});
`endif
        chk({tag, "_done_pulses"}, 32'(dones), 32'h1);
    endtask

    task automatic post_done(input string tag);
        tick();
        chk({tag, "_done_low"}, 32'(done), 32'h0);
        chk({tag, "_idle_busy"}, 32'(busy), 32'h0);
        chk({tag, "_idle_br_en"}, 32'(br_enable), 32'h0);
        chk({tag, "_idle_addr"}, 32'(br_addr), 32'h0);
    endtask

    initial begin
        logic act_en, act_busy, act_valid;
        rst_n    = 1'b0;
        start    = 1'b0;
        halted   = 1'b0;
        tx_ready = 1'b1;
        for (int i = 0; i < N_REGS; i++) regs[i] = 32'hA0B0C000 + 32'(i);
        tick();
        tick();

        // reset state
        chk("rst_br_enable", 32'(br_enable), 32'h0);
        chk("rst_br_addr", 32'(br_addr), 32'h0);
        chk("rst_tx_valid", 32'(tx_valid), 32'h0);
        chk("rst_tx_data", 32'(tx_data), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        rst_n = 1'b1;
        tick();

        // start while not halted is ignored
        halted = 1'b0;
        start  = 1'b1;
        tick();
        start = 1'b0;
        act_en = 1'b0; act_busy = 1'b0; act_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            act_en    |= br_enable;
            act_busy  |= busy;
            act_valid |= tx_valid;
            tick();
        end
        chk("nohalt_br_enable", 32'(act_en), 32'h0);
        chk("nohalt_busy", 32'(act_busy), 32'h0);
        chk("nohalt_tx_valid", 32'(act_valid), 32'h0);

        // latency, full stream, halted dropping mid-dump
        halted = 1'b1;
        start  = 1'b1;
        tick();
        chk("lat_br_enable", 32'(br_enable), 32'h1);
        chk("lat_br_addr", 32'(br_addr), 32'h0);
        chk("lat_busy", 32'(busy), 32'h1);
        chk("lat_valid_n1", 32'(tx_valid), 32'h0);
        start  = 1'b0;
        halted = 1'b0;
        tick();
        chk("lat_valid_n2", 32'(tx_valid), 32'h0);
        chk("capture_br_enable", 32'(br_enable), 32'h1);
        tick();
        chk("lat_valid_n3", 32'(tx_valid), 32'h1);
        chk("lat_first_byte", 32'(tx_data), 32'hA0);
        collect(0, 0);
        check_stream("basic");
        post_done("basic");

        // back-pressure 1-0-0-1
        start_dump();
        collect(1, 0);
        check_stream("stall");
        post_done("stall");

        // start pulses mid-dump are not queued
        start_dump();
        collect(2, 0);
        check_stream("midstart");
        post_done("midstart");
        act_busy = 1'b0;
        for (int i = 0; i < 10; i++) begin
            act_busy |= busy;
            tick();
        end
        chk("midstart_not_queued", 32'(act_busy), 32'h0);

        // asynchronous reset while byte 50 is offered
        start_dump();
        collect(0, 50);
        chk("pre_reset_bytes", 32'(got.size()), 32'd50);
        rst_n = 1'b0;
        #1;
        chk("areset_tx_valid", 32'(tx_valid), 32'h0);
        chk("areset_br_enable", 32'(br_enable), 32'h0);
        chk("areset_busy", 32'(busy), 32'h0);
        chk("areset_done", 32'(done), 32'h0);
        chk("areset_tx_data", 32'(tx_data), 32'h0);
        chk("areset_br_addr", 32'(br_addr), 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        start_dump();
        collect(0, 0);
        check_stream("after_reset");
        post_done("after_reset");

`ifdef DUMP_CHECKSUM_EN
        // checksum of identical words cancels out
        for (int i = 0; i < N_REGS; i++) regs[i] = 32'h01010101;
        start_dump();
        collect(0, 0);
        check_stream("cksum");
        if (got.size() == N_STREAM) chk("cksum_zero", {24'h0, got[N_STREAM-1]}, 32'h0);
        post_done("cksum");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
